// File: rtl/mat_mul_pkg.sv
// Shared types and helpers for the streaming N x N matrix-multiply engine.
package mat_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_e;

  localparam int N_DEFAULT = 8;
  localparam int ROW_CNT_W = $clog2(N_DEFAULT);

  // Flat element index of (r,c) in a row-major packed N x N matrix.
  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  function automatic int row_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_mul_stream_if.sv
// Operand/result handshake bundle between the operand fetch stage, the engine and writeback.
interface mat_mul_stream_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [N*N*W_IN-1:0]    matrix_1;
  logic [N*N*W_IN-1:0]    matrix_2;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*N*W_OUT-1:0]   result;

  modport master (
    output in_valid, mode, matrix_1, matrix_2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mode, matrix_1, matrix_2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mat_mul_row.sv
// One result row: N signed dot products of an A row against every column of B.
module mat_mul_row
  import mat_mul_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 8
) (
  input  logic [N*W_IN-1:0]   a_row_i,
  input  logic [N*N*W_IN-1:0] b_i,
  output logic [N*W_OUT-1:0]  dot_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    logic signed [2*W_IN-1:0] prod [N];
    logic signed [W_OUT-1:0]  sum;

    // Products are sign-extended to W_OUT; the sum wraps modulo 2^W_OUT.
    always_comb begin
      prod = '{default: '0};
      sum  = '0;
      for (int k = 0; k < N; k++) begin
        prod[k] = $signed(a_row_i[k*W_IN +: W_IN]) *
                  $signed(b_i[elem_idx(k, gi, N)*W_IN +: W_IN]);
        sum     = sum + W_OUT'(prod[k]);
      end
    end

    assign dot_o[gi*W_OUT +: W_OUT] = sum;
  end

endmodule

// File: rtl/mat_mul_stream.sv
// Handshaked N x N signed matrix multiplier, one result row per cycle, with
// optional accumulation into the held result for K-tiled products.
module mat_mul_stream
  import mat_mul_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cen,
  mat_mul_stream_if.slave  bus
);

  localparam int CW   = row_cnt_w(N);
  localparam int AROW = N * W_IN;
  localparam int CROW = N * W_OUT;

  state_e                 state_q, state_d;
  logic [CW-1:0]          row_q, row_d;
  logic [N*N*W_IN-1:0]    a_q, b_q;
  logic                   mode_q;
  logic                   in_ready_q, out_valid_q;
  logic [N*N*W_OUT-1:0]   result_q;
  logic                   load, wr;

  logic [AROW-1:0]        a_row;
  logic [CROW-1:0]        dot_row, old_row, new_row;

  assign a_row   = a_q[int'(row_q)*AROW +: AROW];
  assign old_row = result_q[int'(row_q)*CROW +: CROW];

  mat_mul_row #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT),
    .N     (N)
  ) u_row (
    .a_row_i (a_row),
    .b_i     (b_q),
    .dot_o   (dot_row)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_acc
    assign new_row[gi*W_OUT +: W_OUT] = mode_q
      ? old_row[gi*W_OUT +: W_OUT] + dot_row[gi*W_OUT +: W_OUT]
      : dot_row[gi*W_OUT +: W_OUT];
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = COMPUTE;
          row_d   = '0;
          load    = 1'b1;
        end
      end
      COMPUTE: begin
        wr = 1'b1;
        if (row_q == CW'(N - 1)) begin
          state_d = DONE;
          row_d   = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so outputs never
  // depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (cen) begin
      state_q     <= state_d;
      row_q       <= row_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      if (load) begin
        a_q    <= bus.matrix_1;
        b_q    <= bus.matrix_2;
        mode_q <= bus.mode;
      end
      if (wr) result_q[int'(row_q)*CROW +: CROW] <= new_row;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mat_mul_stream.sv
// Directed bench: table of jobs on an 8x8 engine plus hand-written corner sequences.
module tb_mat_mul_stream;

  localparam int N  = 8;
  localparam int WI = 8;
  localparam int WO = 32;
  localparam int AW = N * N * WI;
  localparam int RW = N * N * WO;
  localparam int NV = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic cen  = 1'b1;
  always #5 clk = ~clk;

  mat_mul_stream_if #(.W_IN(WI), .W_OUT(WO), .N(N)) bus ();
  mat_mul_stream_if #(.W_IN(8), .W_OUT(16), .N(2)) bus16 ();
  mat_mul_stream_if #(.W_IN(8), .W_OUT(32), .N(2)) bus32 ();

  mat_mul_stream #(.W_IN(WI), .W_OUT(WO), .N(N)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .bus(bus)
  );
  mat_mul_stream #(.W_IN(8), .W_OUT(16), .N(2)) dut16 (
    .clk(clk), .rstn(rstn), .cen(cen), .bus(bus16)
  );
  mat_mul_stream #(.W_IN(8), .W_OUT(32), .N(2)) dut32 (
    .clk(clk), .rstn(rstn), .cen(cen), .bus(bus32)
  );

  typedef struct {
    logic          mode;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t  vecs [NV];
  string vname [NV];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    int bad = -1;
    checks++;
    for (int e = N * N - 1; e >= 0; e--)
      if (act[e*WO +: WO] !== exp[e*WO +: WO]) bad = e;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: element %0d got %0d expected %0d", name, bad,
               $signed(act[bad*WO +: WO]), $signed(exp[bad*WO +: WO]));
    end
  endtask

  // Operand patterns: 0 identity, 1 all ones, 2 values 1..N*N row-major, 3 minus identity.
  function automatic logic [AW-1:0] op_fill(input int kind);
    logic [AW-1:0] m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int v;
        case (kind)
          0: v = (r == c) ? 1 : 0;
          1: v = 1;
          2: v = r * N + c + 1;
          default: v = (r == c) ? -1 : 0;
        endcase
        m[(r*N+c)*WI +: WI] = WI'(v);
      end
    return m;
  endfunction

  // Expected results: 0 seq, 1 all N, 2 all 2N, 3 2N - seq, 4 column sums of seq, 5 zero.
  function automatic logic [RW-1:0] res_fill(input int kind);
    logic [RW-1:0] m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int v;
        case (kind)
          0: v = r * N + c + 1;
          1: v = N;
          2: v = 2 * N;
          3: v = 2 * N - (r * N + c + 1);
          4: v = N * N * (N - 1) / 2 + N * (c + 1);
          default: v = 0;
        endcase
        m[(r*N+c)*WO +: WO] = WO'(v);
      end
    return m;
  endfunction

  task automatic start_job(input logic m, input logic [AW-1:0] a, input logic [AW-1:0] b);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.matrix_1 = a;
    bus.matrix_2 = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.matrix_1 = '0;
    bus.matrix_2 = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after_pop", 64'(bus.in_ready), 64'd1);
    chk("out_valid_after_pop", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;

    bus.in_valid = 0; bus.mode = 0; bus.matrix_1 = '0; bus.matrix_2 = '0; bus.out_ready = 0;
    bus16.in_valid = 0; bus16.mode = 0; bus16.matrix_1 = '0; bus16.matrix_2 = '0; bus16.out_ready = 0;
    bus32.in_valid = 0; bus32.mode = 0; bus32.matrix_1 = '0; bus32.matrix_2 = '0; bus32.out_ready = 0;

    vecs[0] = '{1'b0, op_fill(0), op_fill(2), res_fill(0)}; vname[0] = "ident_x_seq";
    vecs[1] = '{1'b0, op_fill(1), op_fill(1), res_fill(1)}; vname[1] = "ones_overwrite";
    vecs[2] = '{1'b1, op_fill(1), op_fill(1), res_fill(2)}; vname[2] = "ones_accumulate";
    vecs[3] = '{1'b1, op_fill(3), op_fill(2), res_fill(3)}; vname[3] = "neg_ident_accumulate";
    vecs[4] = '{1'b0, op_fill(1), op_fill(2), res_fill(4)}; vname[4] = "ones_x_seq";

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_res("reset_result", bus.result, res_fill(5));
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      start_job(vecs[i].mode, vecs[i].a, vecs[i].b);
      wait_out(lat);
      chk({vname[i], "_latency"}, 64'(lat), 64'(N));
      chk({vname[i], "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
      check_res({vname[i], "_result"}, bus.result, vecs[i].exp);
      $display("job %s mode=%0d latency=%0d", vname[i], vecs[i].mode, lat);
      pop();
    end

    // Backpressure with a competing in_valid that must be ignored.
    start_job(1'b0, op_fill(0), op_fill(2));
    wait_out(lat);
    bus.in_valid = 1'b1; bus.mode = 1'b1; bus.matrix_1 = op_fill(1); bus.matrix_2 = op_fill(1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== res_fill(0)) bad++;
    end
    chk("backpressure_hold", 64'(bad), 64'd0);
    bus.in_valid = 1'b0;
    $display("job backpressure held 20 cycles, bad=%0d", bad);
    pop();
    check_res("retained_after_pop", bus.result, res_fill(0));

    // Clock enable dropped for 3 cycles mid-COMPUTE, then while DONE with out_ready high.
    start_job(1'b0, op_fill(1), op_fill(1));
    repeat (2) @(negedge clk);
    cen = 1'b0;
    repeat (3) @(negedge clk);
    chk("cen_stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("cen_stall_out_valid", 64'(bus.out_valid), 64'd0);
    cen = 1'b1;
    wait_out(lat);
    chk("cen_latency", 64'(lat + 5), 64'(N + 3));
    check_res("cen_result", bus.result, res_fill(1));
    $display("job cen_stall latency=%0d", lat + 5);
    cen = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("cen_blocks_output_transfer", 64'(bus.out_valid), 64'd1);
    cen = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("cen_release_pops", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of an accumulate job discards job and accumulator.
    start_job(1'b1, op_fill(1), op_fill(1));
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midjob_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midjob_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_res("midjob_reset_result", bus.result, res_fill(5));
    rstn = 1'b1;
    @(negedge clk);
    start_job(1'b1, op_fill(0), op_fill(2));
    wait_out(lat);
    check_res("accumulate_after_reset", bus.result, res_fill(0));
    $display("job post_reset_accumulate latency=%0d", lat);
    pop();

    // Wrap-around: every element -128 on N=2 engines with 16- and 32-bit results.
    bus16.matrix_1 = {4{8'h80}}; bus16.matrix_2 = {4{8'h80}}; bus16.mode = 1'b0;
    bus32.matrix_1 = {4{8'h80}}; bus32.matrix_2 = {4{8'h80}}; bus32.mode = 1'b0;
    bus16.in_valid = 1'b1;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wrap16_latency", 64'(lat), 64'd2);
    chk("wrap32_out_valid", 64'(bus32.out_valid), 64'd1);
    chk("wrap16_result", 64'(bus16.result), {4{16'h8000}});
    chk("wrap32_result_lo", bus32.result[63:0], {2{32'h0000_8000}});
    chk("wrap32_result_hi", bus32.result[127:64], {2{32'h0000_8000}});
    $display("job wrap_n2 w16=0x%0h", bus16.result);
    bus16.out_ready = 1'b1;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    bus32.out_ready = 1'b0;
    chk("wrap16_popped", 64'(bus16.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_mul_stream.md
# mat_mul_stream

Parametrised, handshaked successor to the single-shot matrix-multiply wrapper. It accepts two signed N×N operand matrices over a valid/ready port and computes one result row per cycle. It can either overwrite or accumulate into the held result, which supports K-tiled products. The result is presented on a valid/ready output port. It sits between the SIMD operand fetch stage and the writeback stage.

## Interface
- `W_IN`, 8: signed operand element width.
- `W_OUT`, 32: signed result element width. Must satisfy W_OUT ≥ 2·W_IN + clog2(N).
- `N`, 8: matrix dimension, ≥ 2.
- `clk` in 1: the single clock.
- `rstn` in 1: synchronous, active-low reset.
- `cen` in 1: clock enable. When low, all state holds and no handshake completes.
- `in_valid` in 1: operand job valid.
- `in_ready` out 1: engine can accept a job.
- `mode` in 1: sampled with the job. 0 = overwrite (C = A·B); 1 = accumulate (C = C + A·B).
- `matrix_1` in N·N·W_IN: operand A. Element (r,c) is at bits [(r·N+c)·W_IN +: W_IN].
- `matrix_2` in N·N·W_IN: operand B, same packing as A.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out N·N·W_OUT: C, packed like A with element width W_OUT.

## Operation
- FSM has three states: IDLE, COMPUTE, DONE. It changes state only on a clk edge with `cen`=1.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1, the job is accepted: A, B and `mode` are latched, the row counter is set to 0, and the FSM moves to COMPUTE.
- COMPUTE:
  - Each cycle writes row i of C, where c[i][j] = Σk a[i][k]·b[k][j]. With mode=1, the old c[i][j] is added to that sum.
  - The row counter increments. After row N−1 the FSM moves to DONE.
- DONE:
  - `out_valid`=1 and `result` is stable.
  - When `out_ready`=1, the FSM moves to IDLE. `result` is retained so that the next job can accumulate into it.
- Arithmetic:
  - All values are signed two's complement.
  - Each product is 2·W_IN bits and is sign-extended to W_OUT before summation.
  - Sums and accumulation wrap modulo 2^W_OUT. There is no saturation.
- `in_valid` is ignored outside IDLE. Input ports need not stay stable after acceptance.
- When `cen`=0: registers hold, `in_ready` and `out_valid` keep their values, and no transfer counts even if valid and ready are both high.
- Reset (`rstn`=0 at a clk edge, regardless of `cen`):
  - FSM goes to IDLE, the row counter to 0, `result` to 0, `out_valid` to 0, `in_ready` to 1.
  - A reset during COMPUTE or DONE discards the job and the accumulator.

## Timing
- Job accepted at edge t. Rows 0..N−1 are written at edges t+1..t+N. `out_valid`=1 from edge t+N onward.
- Minimum job-to-job interval is N+2 cycles:
  - accept;
  - N compute cycles;
  - the DONE handshake cycle, which returns the FSM to IDLE;
  - the next accept.
- `in_ready`, `out_valid` and `result` are registered outputs. There is no combinational path from any input to any output.
- Backpressure: DONE holds indefinitely while `out_ready`=0.

## Structure
- Package `mat_mul_pkg` contains:
  - the state enum (IDLE, COMPUTE, DONE);
  - an element-index helper function;
  - a localparam for the row-counter width, clog2(N).
- Sub-module `mat_mul_row` (combinational) takes one A row and all of B and returns N dot products of W_OUT bits. It holds N·N multipliers. The top level holds the FSM, operand latches, row counter, mux and accumulator.

## Test plan
- Reset, then A = identity, B = element values 1..N² in row-major order, mode=0 → `out_valid` at t+N and `result` = B.
- A and B both all-ones, mode=0, then the same job again with mode=1 → first result is N everywhere, second is 2N everywhere.
- Hold `out_ready`=0 for 20 cycles in DONE → `out_valid` and `result` stay stable and `in_ready`=0. Raising `in_valid` meanwhile is ignored.
- Drop `cen` for 3 cycles mid-COMPUTE → `out_valid` appears 3 cycles late and the result is unchanged.
- Assert `rstn`=0 for one cycle at row 2 of a mode=1 job → `in_ready`=1, `out_valid`=0, `result`=0 after the edge. The next mode=1 job equals the bare A·B.
- With W_IN=8, every element −128 in both A and B, W_OUT=16, N=2 → each element is 32768, which wraps to −32768. The same job with W_OUT=32 gives 32768.
